fib_scheduler: RTL

Shares one `fibonacci` engine (5-bit index in, 20-bit result out, start/done_tick handshake) between `N_REQ` requesters. A round-robin arbiter picks one pending request, the scheduler issues a single-cycle start to the engine, captures the result on `done_tick`, and returns it to the winning requester with a one-cycle valid pulse. The block sits between the requesting clients and the single engine instance and is the only driver of the engine's `start`/`i` inputs.

---
 rtl/fib_pkg.sv | 17 +
 rtl/fib_scheduler_if.sv | 31 +++
 rtl/fib_rr_arbiter.sv | 31 +++
 rtl/fib_scheduler.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: widths, index limit and scheduler state encoding shared by the
// Fibonacci engine scheduler slice.
package fib_pkg;

  localparam int IDX_W       = 5;
  localparam int F_W         = 20;
  // Largest index whose Fibonacci value still fits in F_W bits
  localparam int FIB_MAX_IDX = 30;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/fib_scheduler_if.sv
// fib_scheduler_if: requester-side bus of the scheduler. Clients drive the
// level requests and indices and receive a one-hot response pulse.
interface fib_scheduler_if
  import fib_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*IDX_W-1:0] req_idx;
  logic [N_REQ-1:0]       rsp_valid;
  logic [F_W-1:0]         rsp_f;
  logic                   rsp_err;

  modport master (
    output req,
    output req_idx,
    input  rsp_valid,
    input  rsp_f,
    input  rsp_err
  );

  modport slave (
    input  req,
    input  req_idx,
    output rsp_valid,
    output rsp_f,
    output rsp_err
  );

endinterface

// File: rtl/fib_rr_arbiter.sv
// fib_rr_arbiter: combinational round-robin pick of the first request at or
// after rr_ptr; the pointer register itself lives in the scheduler.
module fib_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     any
);

  localparam int PTR_W = $clog2(N_REQ);

  always_comb begin
    logic [PTR_W-1:0] pos;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    pos    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        gnt_id   = pos;
      end
    end
  end

endmodule

// File: rtl/fib_scheduler.sv
// fib_scheduler: shares one fibonacci engine between N_REQ requesters.
// Optional macro FIB_SCHED_RANGE_CHECK_EN rejects indices above FIB_MAX_IDX.
module fib_scheduler
  import fib_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fib_scheduler_if.slave   bus,
  output logic             busy,
  output logic             fib_start,
  output logic [IDX_W-1:0] fib_i,
  input  logic             fib_done_tick,
  input  logic [F_W-1:0]   fib_f
);

  localparam int PTR_W = $clog2(N_REQ);

  sched_state_t     state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_id;
  logic [PTR_W-1:0] gnt_id;
  logic [PTR_W-1:0] next_ptr;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] gnt_q;
  logic             any;
  logic [IDX_W-1:0] idx_arr [N_REQ];
  logic [IDX_W-1:0] sel_idx;
  logic             range_err;
  logic [N_REQ-1:0] rsp_valid;
  logic [F_W-1:0]   rsp_f;
  logic             rsp_err;

  fib_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_idx
    assign idx_arr[g] = bus.req_idx[g*IDX_W +: IDX_W];
  end

  assign sel_idx  = idx_arr[gnt_id];
  assign next_ptr = (grant_id == PTR_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef FIB_SCHED_RANGE_CHECK_EN
  assign range_err = (sel_idx > IDX_W'(FIB_MAX_IDX));
`else
  assign range_err = 1'b0;
`endif

  // Out-of-range grants skip the engine and answer straight from IDLE;
  // response data is held at zero outside the single RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      gnt_q     <= '0;
      rsp_valid <= '0;
      rsp_f     <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      fib_start <= 1'b0;
      fib_i     <= '0;
    end else begin
      fib_start <= 1'b0;
      fib_i     <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            grant_id <= gnt_id;
            gnt_q    <= gnt;
            busy     <= 1'b1;
            if (range_err) begin
              state     <= RESP;
              rsp_valid <= gnt;
              rsp_err   <= 1'b1;
              rsp_f     <= '0;
            end else begin
              state     <= ISSUE;
              fib_start <= 1'b1;
              fib_i     <= sel_idx;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (fib_done_tick) begin
            state     <= RESP;
            rsp_valid <= gnt_q;
            rsp_f     <= fib_f;
            rsp_err   <= 1'b0;
          end
        end
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= '0;
          rsp_f     <= '0;
          rsp_err   <= 1'b0;
          rr_ptr    <= next_ptr;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_f     = rsp_f;
  assign bus.rsp_err   = rsp_err;

endmodule
